// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply job sequencer.
package matmul_pkg;

   localparam int SIZE_COUNT = 8;
   localparam int SIZE_WIDTH = $clog2(SIZE_COUNT);

   // Index 0 is rows-1, index 1 is cols-1.
   typedef logic [1:0][SIZE_WIDTH-1:0] size_pair_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_DRAIN
   } seq_state_t;

   function automatic logic [31:0] c_addr_f(input logic [SIZE_WIDTH-1:0] r,
                                            input logic [SIZE_WIDTH-1:0] c);
      return 32'(r) * 32'(SIZE_COUNT) + 32'(c);
   endfunction

endpackage

// File: rtl/matmul_result_fifo.sv
// Two-entry result FIFO holding {last, data}; push and pop may share a cycle,
// including when full.
module matmul_result_fifo #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/matmul_job_sequencer.sv
// Job sequencer for matrix_multiply_top: accepts a descriptor, runs the engine
// under a timeout, then streams matrix C out through a 2-entry result FIFO.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a descriptor
// START      | one-cycle mm_start pulse, timeout timer loaded
// WAIT_BUSY  | waiting for the engine to raise mm_busy
// WAIT_DONE  | waiting for the engine to drop mm_busy
// DRAIN      | reading C row-major onto the result stream
module matmul_job_sequencer
   import matmul_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  size_pair_t            cmd_a_size,
   input  size_pair_t            cmd_b_size,
   output logic                  mm_start,
   output size_pair_t            mm_a_size,
   output size_pair_t            mm_b_size,
   input  logic                  mm_busy,
   output logic [ADDR_WIDTH-1:0] mm_c_address,
   input  logic [DATA_WIDTH-1:0] mm_c_read_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_last,
   output logic                  done,
   output logic                  err_dim,
   output logic                  err_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_t            state;
   logic [TW-1:0]         tmr;
   logic [SIZE_WIDTH-1:0] row;
   logic [SIZE_WIDTH-1:0] col;
   logic [SIZE_WIDTH-1:0] row_nxt;
   logic [SIZE_WIDTH-1:0] col_nxt;
   logic                  all_issued;
   logic                  rd_pend;
   logic                  rd_last;
   logic                  is_last_elem;
   logic                  issue;
   logic                  pop;
   logic [1:0]            occ_after_pop;
   logic [1:0]            fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH:0]   fifo_head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cmd_ready   <= 1'b1;
         mm_start    <= 1'b0;
         done        <= 1'b0;
         err_dim     <= 1'b0;
         err_timeout <= 1'b0;
         mm_a_size   <= '0;
         mm_b_size   <= '0;
         tmr         <= '0;
      end else begin
         mm_start    <= 1'b0;
         done        <= 1'b0;
         err_dim     <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  if (cmd_a_size[1] != cmd_b_size[0]) begin
                     err_dim <= 1'b1;
                  end else begin
                     mm_a_size <= cmd_a_size;
                     mm_b_size <= cmd_b_size;
                     mm_start  <= 1'b1;
                     cmd_ready <= 1'b0;
                     state     <= ST_START;
                  end
               end
            end
            ST_START: begin
               tmr   <= TW'(TIMEOUT_CYCLES);
               state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               tmr <= tmr - 1'b1;
               // Terminal count wins over a busy edge landing in the same cycle.
               if (tmr == TW'(1)) begin
                  err_timeout <= 1'b1;
                  cmd_ready   <= 1'b1;
                  state       <= ST_IDLE;
               end else if ((state == ST_WAIT_BUSY) && mm_busy) begin
                  state <= ST_WAIT_DONE;
               end else if ((state == ST_WAIT_DONE) && !mm_busy) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && res_last) begin
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign res_valid           = !fifo_empty;
   assign {res_last, res_data} = fifo_head;
   assign pop                 = res_valid && res_ready;
   assign is_last_elem        = (row == mm_a_size[0]) && (col == mm_b_size[1]);

   // The read presented on mm_c_address is committed only when a FIFO slot is
   // guaranteed for its data one cycle later, counting this cycle's pop.
   assign occ_after_pop = fifo_count - {1'b0, pop} + {1'b0, rd_pend};
   assign issue = (state == ST_DRAIN) && !all_issued && (occ_after_pop < 2'd2) &&
                  !(fifo_full && !pop);

   always_comb begin
      row_nxt = row;
      col_nxt = col + 1'b1;
      if (col == mm_b_size[1]) begin
         col_nxt = '0;
         row_nxt = row + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row          <= '0;
         col          <= '0;
         all_issued   <= 1'b0;
         mm_c_address <= '0;
         rd_pend      <= 1'b0;
         rd_last      <= 1'b0;
      end else begin
         rd_pend <= issue;
         rd_last <= issue && is_last_elem;
         if (state != ST_DRAIN) begin
            row          <= '0;
            col          <= '0;
            all_issued   <= 1'b0;
            mm_c_address <= '0;
         end else if (issue) begin
            if (is_last_elem) begin
               all_issued <= 1'b1;
            end else begin
               row          <= row_nxt;
               col          <= col_nxt;
               mm_c_address <= ADDR_WIDTH'(c_addr_f(row_nxt, col_nxt));
            end
         end
      end
   end

   matmul_result_fifo #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pend),
      .push_data ({rd_last, mm_c_read_data}),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Bench for matmul_job_sequencer: behavioural engine and C memory, randomized
// jobs checked against a row-major reference list of expected beats.
`timescale 1ns/1ps
module tb_matmul_job_sequencer;
   import matmul_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   size_pair_t  cmd_a_size = '0;
   size_pair_t  cmd_b_size = '0;
   logic        mm_start;
   size_pair_t  mm_a_size;
   size_pair_t  mm_b_size;
   logic        mm_busy = 1'b0;
   logic [31:0] mm_c_address;
   logic [31:0] mm_c_read_data = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic        res_last;
   logic        done;
   logic        err_dim;
   logic        err_timeout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int busy_len = 0;
   int busy_left = 0;
   int occ_max = 0;
   logic [31:0] c_mem [64];

   matmul_job_sequencer #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a_size(cmd_a_size), .cmd_b_size(cmd_b_size), .mm_start(mm_start),
      .mm_a_size(mm_a_size), .mm_b_size(mm_b_size), .mm_busy(mm_busy),
      .mm_c_address(mm_c_address), .mm_c_read_data(mm_c_read_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .done(done), .err_dim(err_dim), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // C memory: data for the address of the ending cycle appears just after the edge.
   always @(posedge clk) begin : mem_model
      logic [31:0] a;
      a = mm_c_address;
      #1 mm_c_read_data = c_mem[a[5:0]];
   end

   // Engine: busy for busy_len cycles starting the cycle after mm_start.
   always @(posedge clk) begin : engine_model
      logic s;
      s = mm_start;
      #1;
      if (s && busy_len > 0) busy_left = busy_len;
      else if (busy_left > 0) busy_left--;
      mm_busy = (busy_left > 0);
   end

   always @(negedge clk) begin
      if (int'(dut.u_fifo.count) + int'(dut.rd_pend) > occ_max)
         occ_max = int'(dut.u_fifo.count) + int'(dut.rd_pend);
   end

   function automatic size_pair_t mk(input int rows_m1, input int cols_m1);
      size_pair_t p;
      p[0] = rows_m1[SIZE_WIDTH-1:0];
      p[1] = cols_m1[SIZE_WIDTH-1:0];
      return p;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < 64; i++) c_mem[i] = $urandom;
   endtask

   // mode 0: ready always, 1: ready on alternate cycles, 2: random ready.
   task automatic run_job(input size_pair_t a, input size_pair_t b, input int blen,
                          input int mode, input bit hold, input bit skip_cmd);
      logic [32:0] exp_q[$];
      logic [32:0] beat;
      logic [32:0] prev_beat = '0;
      bit prev_stall = 1'b0;
      int t0, n;
      int first_v = -1, first_acc = -1, last_acc = -1, done_cyc = -1;
      int starts = 0, stab_err = 0, size_err = 0, ready_err = 0, extra = 0;
      for (int r = 0; r <= int'(a[0]); r++)
         for (int c = 0; c <= int'(b[1]); c++)
            exp_q.push_back({(r == int'(a[0]) && c == int'(b[1])), c_mem[r*SIZE_COUNT + c]});
      n = exp_q.size();
      busy_len = blen;
      if (!skip_cmd) begin
         cmd_a_size = a;
         cmd_b_size = b;
         cmd_valid  = 1'b1;
      end
      t0 = cyc;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL job_accept cmd_ready=%b want 1", cmd_ready); end
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      checks++;
      if (mm_start !== 1'b1 || err_dim !== 1'b0) begin
         errors++; $display("FAIL start_pulse mm_start=%b err_dim=%b want 1/0", mm_start, err_dim);
      end
      for (int k = 0; k < 3000; k++) begin
         if (k > 0) @(negedge clk);
         if (mm_start === 1'b1) starts++;
         if (done === 1'b1) begin done_cyc = cyc; break; end
         if (cmd_ready !== 1'b0) ready_err++;
         if (mm_a_size !== a || mm_b_size !== b) size_err++;
         case (mode)
            0: res_ready = 1'b1;
            1: res_ready = (cyc % 2 == 0);
            default: res_ready = ($urandom_range(3) != 0);
         endcase
         beat = {res_last, res_data};
         if (prev_stall && (res_valid !== 1'b1 || beat !== prev_beat)) stab_err++;
         if (res_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (res_valid === 1'b1 && res_ready) begin
            if (exp_q.size() == 0) extra++;
            else begin
               checks++;
               if (beat !== exp_q[0]) begin
                  errors++; $display("FAIL beat_%0d got=%h want=%h", n - exp_q.size(), beat, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
         prev_stall = (res_valid === 1'b1) && !res_ready;
         prev_beat  = beat;
      end
      checks++;
      if (done_cyc < 0) begin errors++; $display("FAIL job_done_timeout got=none want done"); end
      checks++;
      if (exp_q.size() != 0 || extra != 0) begin
         errors++; $display("FAIL beat_count missing=%0d extra=%0d want 0/0", exp_q.size(), extra);
      end
      checks++;
      if (done_cyc != last_acc + 1) begin errors++; $display("FAIL done_timing got=%0d want=%0d", done_cyc, last_acc + 1); end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_at_done got=%b want 1", cmd_ready); end
      checks++;
      if (starts != 1) begin errors++; $display("FAIL start_count got=%0d want 1", starts); end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL stall_stability got=%0d want 0", stab_err); end
      checks++;
      if (size_err != 0 || ready_err != 0) begin
         errors++; $display("FAIL hold_sizes_ready size_err=%0d ready_err=%0d want 0/0", size_err, ready_err);
      end
      checks++;
      if (first_v < t0 + blen + 5) begin errors++; $display("FAIL first_valid_early got=%0d min=%0d", first_v, t0 + blen + 5); end
      if (mode == 0) begin
         checks++;
         if (last_acc - first_acc != n - 1) begin
            errors++; $display("FAIL throughput got=%0d want=%0d", last_acc - first_acc, n - 1);
         end
      end
      if (!hold) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin errors++; $display("FAIL done_single got=%b want 0", done); end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({cmd_ready, mm_start, res_valid, done, err_dim, err_timeout} !== 6'b100000 || mm_c_address !== '0) begin
         errors++; $display("FAIL reset_outputs got=%b addr=%h want 100000/0",
                            {cmd_ready, mm_start, res_valid, done, err_dim, err_timeout}, mm_c_address);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, mm_start, res_valid, done} !== 4'b1000 || mm_a_size !== '0 || mm_b_size !== '0) begin
         errors++; $display("FAIL post_reset got=%b want 1000", {cmd_ready, mm_start, res_valid, done});
      end
   endtask

   task automatic test_dim_error(input size_pair_t a, input size_pair_t b);
      cmd_a_size = a;
      cmd_b_size = b;
      cmd_valid  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if ({err_dim, mm_start, cmd_ready} !== 3'b101) begin
         errors++; $display("FAIL dim_err_t1 got=%b want 101", {err_dim, mm_start, cmd_ready});
      end
      @(negedge clk);
      checks++;
      if ({err_dim, mm_start} !== 2'b00) begin errors++; $display("FAIL dim_err_after got=%b want 00", {err_dim, mm_start}); end
   endtask

   task automatic test_timeout();
      int t0, tcyc = -1, starts = 0;
      bit rv = 1'b0;
      busy_len   = 0;
      cmd_a_size = mk(1, 1);
      cmd_b_size = mk(1, 1);
      cmd_valid  = 1'b1;
      t0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (k > 0) @(negedge clk);
         if (mm_start === 1'b1) starts++;
         if (res_valid !== 1'b0) rv = 1'b1;
         if (err_timeout === 1'b1) begin tcyc = cyc; break; end
      end
      checks++;
      if (tcyc != t0 + 2 + TMO) begin errors++; $display("FAIL timeout_cycle got=%0d want=%0d", tcyc, t0 + 2 + TMO); end
      checks++;
      if (cmd_ready !== 1'b1 || rv || starts != 1) begin
         errors++; $display("FAIL timeout_state ready=%b res_valid_seen=%b starts=%0d want 1/0/1", cmd_ready, rv, starts);
      end
      @(negedge clk);
      checks++;
      if ({err_timeout, res_valid} !== 2'b00) begin errors++; $display("FAIL timeout_pulse got=%b want 00", {err_timeout, res_valid}); end
   endtask

   task automatic test_reset_mid_job();
      int acc = 0;
      bit hit = 1'b0;
      fill_mem();
      busy_len   = 3;
      res_ready  = 1'b1;
      cmd_a_size = mk(2, 2);
      cmd_b_size = mk(2, 2);
      cmd_valid  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            if (acc == 2) begin hit = 1'b1; break; end
            acc++;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL reset_job_reach_beat3 got=%0d beats want 3", acc); end
      reset = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, mm_start, res_valid, res_last, done, err_dim, err_timeout} !== 7'b1000000 ||
          mm_c_address !== '0 || res_data !== '0 || mm_a_size !== '0) begin
         errors++; $display("FAIL async_reset got=%b addr=%h data=%h want 1000000/0/0",
                            {cmd_ready, mm_start, res_valid, res_last, done, err_dim, err_timeout}, mm_c_address, res_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 50 && mm_busy; k++) @(negedge clk);
      @(negedge clk);
      fill_mem();
      run_job(mk(2, 2), mk(2, 2), 4, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      fill_mem();
      run_job(mk(1, 3), mk(3, 2), 4, 0, 1'b1, 1'b0);
      run_job(mk(1, 3), mk(3, 2), 2, 2, 1'b0, 1'b1);
   endtask

   initial begin
      fill_mem();
      test_reset();
      fill_mem();
      run_job(mk(1, 2), mk(2, 1), 5, 0, 1'b0, 1'b0);
      test_dim_error(mk(1, 2), mk(1, 1));
      for (int i = 0; i < 3; i++) begin : rand_dim
         int a1;
         a1 = $urandom_range(7);
         test_dim_error(mk($urandom_range(7), a1), mk((a1 + 1 + $urandom_range(6)) % 8, $urandom_range(7)));
      end
      fill_mem();
      run_job(mk(7, 7), mk(7, 7), $urandom_range(1, 8), 1, 1'b0, 1'b0);
      run_job(mk(0, 0), mk(0, 0), 1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin : rand_jobs
         int k;
         fill_mem();
         k = $urandom_range(7);
         run_job(mk($urandom_range(7), k), mk(k, $urandom_range(7)), $urandom_range(1, 8), 2, 1'b0, 1'b0);
      end
      test_timeout();
      test_reset_mid_job();
      test_back_to_back();
      checks++;
      if (occ_max > 2) begin errors++; $display("FAIL credit_occupancy got=%0d max=2", occ_max); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matmul_job_sequencer.md
# matmul_job_sequencer

Sequences one matrix-multiply job end to end in front of the `matrix_multiply_top` datapath. It accepts a job descriptor over a valid/ready handshake and rejects dimension-incompatible jobs. For accepted jobs it pulses the engine `start`, supervises `busy` with a timeout, then drains matrix C element by element onto a back-pressured result stream. It sits between the host/command fabric and the engine's start/size/C-read ports.

## Interface
- `SIZE_COUNT`, 8: maximum matrix dimension; `SIZE_WIDTH = $clog2(SIZE_COUNT)` (localparam).
- `ADDR_WIDTH`, 32: C-memory address width.
- `DATA_WIDTH`, 32: element width.
- `TIMEOUT_CYCLES`, 4096: maximum cycles from `mm_start` to `mm_busy` falling.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cmd_valid`  input  1  job descriptor valid.
- `cmd_ready`  output  1  sequencer can accept a job.
- `cmd_a_size[2]`  input  SIZE_WIDTH each  A {rows-1, cols-1}.
- `cmd_b_size[2]`  input  SIZE_WIDTH each  B {rows-1, cols-1}.
- `mm_start`  output  1  one-cycle engine start pulse.
- `mm_a_size[2]`, `mm_b_size[2]`  output  SIZE_WIDTH each  latched sizes to engine.
- `mm_busy`  input  1  engine busy.
- `mm_c_address`  output  ADDR_WIDTH  C read word address.
- `mm_c_read_data`  input  DATA_WIDTH  C read data, valid 1 cycle after address.
- `res_valid` / `res_ready`  output / input  1  result stream handshake.
- `res_data`  output  DATA_WIDTH  C element.
- `res_last`  output  1  final element of job.
- `done`, `err_dim`, `err_timeout`  output  1  one-cycle status pulses.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, DRAIN.
- IDLE: `cmd_ready`=1. On handshake, latch sizes. If `a_size[1] != b_size[0]`, pulse `err_dim` and stay in IDLE. Otherwise go to START.
- START: `mm_start`=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: on `mm_busy`=1, go to WAIT_DONE.
- WAIT_DONE: on `mm_busy`=0, go to DRAIN.
- Timeout counter clears at START and counts in WAIT_BUSY/WAIT_DONE. On reaching `TIMEOUT_CYCLES`: pulse `err_timeout`, go to IDLE, no drain.
- DRAIN:
  - Read order is row-major, r = 0..a_size[0], c = 0..b_size[1].
  - `mm_c_address = r*SIZE_COUNT + c`, zero-extended.
  - Reads land in a 2-entry result FIFO. A read issues only when occupancy + in-flight < 2.
  - `res_last` accompanies the element (a_size[0], b_size[1]).
  - When the last beat is accepted: pulse `done`, go to IDLE.
- `mm_a_size`/`mm_b_size` hold the latched values from START to end of DRAIN.
- Reset values: `cmd_ready`=1; all other outputs 0.

## Timing
- Handshake at cycle T: `mm_start` or `err_dim` high at T+1.
  - After `err_dim`, `cmd_ready` is high again at T+1.
- First DRAIN cycle D: first address registered at D, `res_valid` no earlier than D+2.
- With `res_ready` held high, throughput is one beat per cycle.
- `res_data`/`res_last` are stable while `res_valid`=1 and `res_ready`=0.
- `done` is high the cycle after the last accepted beat; `cmd_ready` is high that same cycle.
- Boundary conditions:
  - 1x1 job: single beat with `res_last`=1.
  - `mm_busy` already high at START exit: WAIT_BUSY lasts one cycle.
  - FIFO full and `res_ready`=1 in the same cycle: pop and push together; no read stall beyond credit.
- Reset asserted mid-job: all outputs return to reset values asynchronously and the FIFO empties. An engine job in flight is not aborted; the host must not issue a new job until `mm_busy`=0.

## Structure
- Shared package `matmul_pkg`: FSM state enum, `size_pair_t` (2 x SIZE_WIDTH), `c_addr_f(r, c)` address function.
- Sub-module `matmul_result_fifo`: 2-deep FIFO, synchronous push/pop, `full`/`empty`/`count`; carries `{res_last, data}`.

## Test plan
- A {1,2}, B {2,1} (2x3 · 3x2), `mm_busy` high 5 cycles: addresses 0,1,8,9. Four beats, `res_last` on 4th, `done` once.
- A {1,2}, B {1,1}: `err_dim` at T+1, no `mm_start`, `cmd_ready`=1 at T+1.
- 8x8 · 8x8 with `res_ready` pattern 1,0,1,0: 64 beats in row-major order, no loss or duplicates, in-flight+occupancy ≤ 2, data stable while stalled.
- `TIMEOUT_CYCLES`=16, `mm_busy` never asserted: `err_timeout` exactly 16 cycles after WAIT_BUSY entry, IDLE, no `res_valid`.
- `reset` low for 2 cycles during DRAIN beat 3: outputs at reset values immediately; a fresh job afterwards streams from element (0,0).
- `cmd_valid` held high through a job: `cmd_ready` low START..DRAIN; second job accepted in the `done` cycle.
